// File: rtl/conv_window_router.sv
// im2col window router: holds a channel-major ifmap in a register file and
// streams one KxK channel window per cycle to the systolic array rows.
module conv_window_router #(
    parameter  int dataSize       = 8,
    parameter  int numRegister    = 1024,
    parameter  int maxKernelWidth = 3,
    parameter  int nElementsOut   = 9,
    localparam int nAddress       = $clog2(numRegister)
) (
    input  logic                                   clk,
    input  logic                                   nrst,
    input  logic [dataSize-1:0]                    wr_data,
    input  logic [nAddress-1:0]                    wr_addr,
    input  logic                                   wr_en,
    input  logic [15:0]                            cfg_ifmap_width,
    input  logic [3:0]                             cfg_kernel_width,
    input  logic [3:0]                             cfg_stride,
    input  logic [3:0]                             cfg_pad,
    input  logic [15:0]                            cfg_channels,
    input  logic                                   ctrl_start,
    input  logic                                   ctrl_abort,
    output logic [nElementsOut-1:0][dataSize-1:0]  rd_data,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic                                   flag_done,
    output logic                                   flag_error
);

    // state  | meaning
    // S_IDLE | waiting for ctrl_start; config checked on the start cycle
    // S_RUN  | streaming windows, oy outer / ox middle / channel inner
    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [dataSize-1:0] r_mem [numRegister];

    logic [15:0] r_w;
    logic [3:0]  r_k;
    logic [3:0]  r_s;
    logic [3:0]  r_p;
    logic [15:0] r_ch;
    logic [17:0] r_wo;

    logic [17:0] r_ox;
    logic [17:0] r_oy;
    logic [15:0] r_c;
    logic        r_valid;
    logic        r_issued_all;

    logic signed [17:0] w_span;
    logic [3:0]         w_divisor;
    logic [17:0]        w_wo;
    logic               w_cfg_bad;
    logic               w_accept;
    logic               w_reject;
    logic               w_abort;
    logic               w_load;
    logic               w_finish;
    logic               w_is_last;

    logic [dataSize-1:0]                   w_pix [maxKernelWidth][maxKernelWidth];
    logic [nElementsOut-1:0][dataSize-1:0] w_lanes;

    assign out_valid = r_valid;

    assign w_span    = $signed({2'b00, cfg_ifmap_width})
                     + $signed({13'd0, cfg_pad, 1'b0})
                     - $signed({14'd0, cfg_kernel_width});
    assign w_divisor = (cfg_stride == 4'd0) ? 4'd1 : cfg_stride;
    assign w_wo      = ($unsigned(w_span) / {14'd0, w_divisor}) + 18'd1;
    assign w_cfg_bad = (cfg_kernel_width == 4'd0)
                     || (cfg_kernel_width > 4'(maxKernelWidth))
                     || (cfg_stride == 4'd0)
                     || (cfg_channels == 16'd0)
                     || (w_span < 18'sd0);

    assign w_is_last = (r_c == r_ch - 16'd1)
                     && (r_ox == r_wo - 18'd1)
                     && (r_oy == r_wo - 18'd1);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_reject    = 1'b0;
        w_abort     = 1'b0;
        w_load      = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            S_IDLE: begin
                // start beats abort here because abort is simply not looked at
                if (ctrl_start) begin
                    if (w_cfg_bad) begin
                        w_reject = 1'b1;
                    end else begin
                        w_accept    = 1'b1;
                        w_state_nxt = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (ctrl_abort) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (!r_valid || out_ready) begin
                    if (r_valid && r_issued_all) begin
                        w_finish    = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else if (!r_issued_all) begin
                        w_load = 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Pixel fetch for every kernel tap; out-of-image or out-of-memory taps read 0.
    always_comb begin
        logic signed [31:0] v_x;
        logic signed [31:0] v_y;
        logic [63:0]        v_addr;
        logic               v_in;
        v_x    = '0;
        v_y    = '0;
        v_addr = '0;
        v_in   = 1'b0;
        for (int j = 0; j < maxKernelWidth; j++) begin
            for (int i = 0; i < maxKernelWidth; i++) begin
                v_x    = $signed({14'd0, r_ox}) * $signed({28'd0, r_s}) + i - $signed({28'd0, r_p});
                v_y    = $signed({14'd0, r_oy}) * $signed({28'd0, r_s}) + j - $signed({28'd0, r_p});
                v_addr = {48'd0, r_c} * {48'd0, r_w} * {48'd0, r_w}
                       + 64'(v_y) * {48'd0, r_w}
                       + 64'(v_x);
                v_in   = (v_x >= 0) && (v_x < $signed({16'd0, r_w}))
                      && (v_y >= 0) && (v_y < $signed({16'd0, r_w}))
                      && (v_addr < 64'(numRegister));
                w_pix[j][i] = v_in ? r_mem[v_addr[nAddress-1:0]] : '0;
            end
        end
    end

    always_comb begin
        for (int n = 0; n < nElementsOut; n++) begin
            w_lanes[n] = '0;
            for (int j = 0; j < maxKernelWidth; j++) begin
                for (int i = 0; i < maxKernelWidth; i++) begin
                    if ((j < int'(r_k)) && (i < int'(r_k)) && (j * int'(r_k) + i == n)) begin
                        w_lanes[n] = w_pix[j][i];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int a = 0; a < numRegister; a++) begin
                r_mem[a] <= '0;
            end
        end else if (wr_en && (int'(wr_addr) < numRegister)) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rd_data      <= '0;
            r_valid      <= 1'b0;
            r_issued_all <= 1'b0;
            flag_done    <= 1'b0;
            flag_error   <= 1'b0;
            r_w          <= '0;
            r_k          <= '0;
            r_s          <= '0;
            r_p          <= '0;
            r_ch         <= '0;
            r_wo         <= '0;
            r_ox         <= '0;
            r_oy         <= '0;
            r_c          <= '0;
        end else begin
            flag_done  <= w_finish;
            flag_error <= w_reject;
            if (w_accept) begin
                r_w          <= cfg_ifmap_width;
                r_k          <= cfg_kernel_width;
                r_s          <= cfg_stride;
                r_p          <= cfg_pad;
                r_ch         <= cfg_channels;
                r_wo         <= w_wo;
                r_ox         <= '0;
                r_oy         <= '0;
                r_c          <= '0;
                r_valid      <= 1'b0;
                r_issued_all <= 1'b0;
            end else if (w_abort || w_finish) begin
                r_valid <= 1'b0;
            end else if (w_load) begin
                rd_data <= w_lanes;
                r_valid <= 1'b1;
                if (w_is_last) begin
                    r_issued_all <= 1'b1;
                end
                if (r_c == r_ch - 16'd1) begin
                    r_c <= '0;
                    if (r_ox == r_wo - 18'd1) begin
                        r_ox <= '0;
                        r_oy <= r_oy + 18'd1;
                    end else begin
                        r_ox <= r_ox + 18'd1;
                    end
                end else begin
                    r_c <= r_c + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_window_router.sv
// Directed bench for conv_window_router: table of configs with hand-computed
// windows, plus stall, abort, error and asynchronous-reset sequences.
module tb_conv_window_router;

    typedef logic [71:0] win_t;

    typedef struct {
        string nm;
        int    w, k, s, p, c;
        int    cnt;
        int    idx;
        win_t  exp;
    } vec_t;

    logic              clk = 1'b0;
    logic              nrst;
    logic [7:0]        wr_data;
    logic [9:0]        wr_addr;
    logic              wr_en;
    logic [15:0]       cfg_ifmap_width;
    logic [3:0]        cfg_kernel_width;
    logic [3:0]        cfg_stride;
    logic [3:0]        cfg_pad;
    logic [15:0]       cfg_channels;
    logic              ctrl_start;
    logic              ctrl_abort;
    logic [8:0][7:0]   rd_data;
    logic              out_valid;
    logic              out_ready;
    logic              flag_done;
    logic              flag_error;

    int   checks   = 0;
    int   failures = 0;
    win_t got[$];
    bit   rdy_pat[$];
    vec_t vecs[10];
    win_t t1[4];

    conv_window_router #(
        .dataSize(8), .numRegister(1024), .maxKernelWidth(3), .nElementsOut(9)
    ) dut (
        .clk(clk), .nrst(nrst),
        .wr_data(wr_data), .wr_addr(wr_addr), .wr_en(wr_en),
        .cfg_ifmap_width(cfg_ifmap_width), .cfg_kernel_width(cfg_kernel_width),
        .cfg_stride(cfg_stride), .cfg_pad(cfg_pad), .cfg_channels(cfg_channels),
        .ctrl_start(ctrl_start), .ctrl_abort(ctrl_abort),
        .rd_data(rd_data), .out_valid(out_valid), .out_ready(out_ready),
        .flag_done(flag_done), .flag_error(flag_error)
    );

    always #5 clk = ~clk;

    function automatic win_t mk(input int l0, l1, l2, l3, l4, l5, l6, l7, l8);
        return {8'(l8), 8'(l7), 8'(l6), 8'(l5), 8'(l4), 8'(l3), 8'(l2), 8'(l1), 8'(l0)};
    endfunction

    task automatic chk_win(input string nm, input win_t act, input win_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic chk_bit(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b expected=%b", nm, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int w, k, s, p, c);
        cfg_ifmap_width  = 16'(w);
        cfg_kernel_width = 4'(k);
        cfg_stride       = 4'(s);
        cfg_pad          = 4'(p);
        cfg_channels     = 16'(c);
    endtask

    task automatic start_run(input bit with_abort);
        ctrl_start = 1'b1;
        ctrl_abort = with_abort;
        tick();
        ctrl_start = 1'b0;
        ctrl_abort = 1'b0;
    endtask

    // Collects accepted windows until flag_done; checks hold under stall and done timing.
    task automatic run_collect(input int maxc, output int cycles);
        bit   stalled;
        bit   last_hs;
        bit   done_seen;
        win_t held;
        int   k;
        got.delete();
        cycles    = 0;
        done_seen = 1'b0;
        last_hs   = 1'b0;
        k         = 0;
        while (cycles < maxc) begin
            out_ready = (k < rdy_pat.size()) ? rdy_pat[k] : 1'b1;
            k++;
            last_hs = out_valid && out_ready;
            if (last_hs) got.push_back(rd_data);
            stalled = out_valid && !out_ready;
            held    = rd_data;
            tick();
            cycles++;
            if (stalled) begin
                chk_win("stall_data_hold", rd_data, held);
                chk_bit("stall_valid_hold", out_valid, 1'b1);
            end
            if (flag_done) begin
                done_seen = 1'b1;
                break;
            end
        end
        out_ready = 1'b1;
        if (!done_seen) begin
            checks++;
            failures++;
            $display("FAIL run_timeout actual=no_done expected=done within %0d cycles", maxc);
        end else begin
            chk_bit("done_after_handshake", last_hs, 1'b1);
            chk_bit("valid_low_at_done", out_valid, 1'b0);
            tick();
            chk_bit("done_one_cycle", flag_done, 1'b0);
        end
    endtask

    initial begin
        int cyc;
        nrst       = 1'b0;
        wr_data    = '0;
        wr_addr    = '0;
        wr_en      = 1'b0;
        ctrl_start = 1'b0;
        ctrl_abort = 1'b0;
        out_ready  = 1'b1;
        set_cfg(4, 3, 1, 0, 1);

        t1[0] = mk(0, 1, 2, 4, 5, 6, 8, 9, 10);
        t1[1] = mk(1, 2, 3, 5, 6, 7, 9, 10, 11);
        t1[2] = mk(4, 5, 6, 8, 9, 10, 12, 13, 14);
        t1[3] = mk(5, 6, 7, 9, 10, 11, 13, 14, 15);

        vecs[0] = '{"w4k3_first",   4, 3, 1, 0, 1,    4,  0, t1[0]};
        vecs[1] = '{"w4k3_last",    4, 3, 1, 0, 1,    4,  3, t1[3]};
        vecs[2] = '{"pad1_corner0", 3, 3, 1, 1, 1,    9,  0, mk(0, 0, 0, 0, 0, 1, 0, 3, 4)};
        vecs[3] = '{"pad1_corner8", 3, 3, 1, 1, 1,    9,  8, mk(4, 5, 0, 7, 8, 0, 0, 0, 0)};
        vecs[4] = '{"stride2_w11",  5, 3, 2, 0, 1,    4,  3, mk(12, 13, 14, 17, 18, 19, 22, 23, 24)};
        vecs[5] = '{"k2_c0",        3, 2, 1, 0, 2,    8,  0, mk(0, 1, 3, 4, 0, 0, 0, 0, 0)};
        vecs[6] = '{"k2_c1",        3, 2, 1, 0, 2,    8,  1, mk(9, 10, 12, 13, 0, 0, 0, 0, 0)};
        vecs[7] = '{"k2_last",      3, 2, 1, 0, 2,    8,  7, mk(13, 14, 16, 17, 0, 0, 0, 0, 0)};
        vecs[8] = '{"span0_c1",     1, 3, 1, 1, 2,    2,  1, mk(0, 0, 0, 0, 1, 0, 0, 0, 0)};
        vecs[9] = '{"addr_over",    4, 1, 1, 0, 70, 1120, 65, mk(0, 0, 0, 0, 0, 0, 0, 0, 0)};

        tick();
        tick();
        chk_bit("rst_valid", out_valid, 1'b0);
        chk_win("rst_data", rd_data, '0);
        chk_bit("rst_done", flag_done, 1'b0);
        chk_bit("rst_error", flag_error, 1'b0);
        nrst = 1'b1;
        tick();

        for (int a = 0; a < 64; a++) begin
            wr_en   = 1'b1;
            wr_addr = 10'(a);
            wr_data = 8'(a);
            tick();
        end
        wr_en = 1'b0;

        // Rejected configs: K=0, K>3, S=0, C=0, W+2P<K.
        for (int e = 0; e < 5; e++) begin
            case (e)
                0: set_cfg(4, 0, 1, 0, 1);
                1: set_cfg(4, 4, 1, 0, 1);
                2: set_cfg(4, 3, 0, 0, 1);
                3: set_cfg(4, 3, 1, 0, 0);
                default: set_cfg(1, 2, 1, 0, 1);
            endcase
            start_run(1'b0);
            chk_bit($sformatf("err%0d_flag", e), flag_error, 1'b1);
            chk_bit($sformatf("err%0d_valid", e), out_valid, 1'b0);
            tick();
            chk_bit($sformatf("err%0d_pulse", e), flag_error, 1'b0);
            chk_bit($sformatf("err%0d_idle", e), out_valid, 1'b0);
        end

        for (int v = 0; v < 10; v++) begin
            set_cfg(vecs[v].w, vecs[v].k, vecs[v].s, vecs[v].p, vecs[v].c);
            start_run(1'b0);
            set_cfg(9, 1, 1, 0, 1);
            run_collect(5000, cyc);
            chk_int({vecs[v].nm, "_count"}, got.size(), vecs[v].cnt);
            chk_int({vecs[v].nm, "_cycles"}, cyc, vecs[v].cnt + 1);
            if (vecs[v].idx < got.size()) begin
                chk_win(vecs[v].nm, got[vecs[v].idx], vecs[v].exp);
            end else begin
                checks++;
                failures++;
                $display("FAIL %s actual=missing expected=window %0d", vecs[v].nm, vecs[v].idx);
            end
        end

        rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        set_cfg(4, 3, 1, 0, 1);
        start_run(1'b0);
        run_collect(200, cyc);
        rdy_pat.delete();
        chk_int("bp_count", got.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < got.size()) chk_win($sformatf("bp_win%0d", i), got[i], t1[i]);
        end

        set_cfg(4, 3, 1, 0, 1);
        start_run(1'b0);
        out_ready = 1'b1;
        tick();
        tick();
        tick();
        ctrl_abort = 1'b1;
        tick();
        ctrl_abort = 1'b0;
        chk_bit("abort_valid", out_valid, 1'b0);
        chk_bit("abort_no_done0", flag_done, 1'b0);
        tick();
        chk_bit("abort_no_done1", flag_done, 1'b0);
        start_run(1'b1);
        run_collect(200, cyc);
        chk_int("replay_count", got.size(), 4);
        if (got.size() > 0) chk_win("replay_first", got[0], t1[0]);

        set_cfg(4, 3, 1, 0, 1);
        start_run(1'b0);
        tick();
        tick();
        chk_bit("pre_reset_valid", out_valid, 1'b1);
        #2;
        nrst = 1'b0;
        #1;
        chk_bit("async_rst_valid", out_valid, 1'b0);
        chk_win("async_rst_data", rd_data, '0);
        chk_bit("async_rst_done", flag_done, 1'b0);
        chk_bit("async_rst_error", flag_error, 1'b0);
        tick();
        nrst = 1'b1;
        tick();
        start_run(1'b0);
        run_collect(200, cyc);
        chk_int("post_rst_count", got.size(), 4);
        if (got.size() > 0) chk_win("post_rst_mem_clear", got[0], '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conv_window_router.md
# conv_window_router

Parametrised im2col router feeding the systolic array's row inputs. It holds a multi-channel ifmap in an internal register file and streams Toeplitz (im2col) windows, one channel window per cycle. Kernel width, stride, zero padding and channel count are runtime-configurable. Output uses a valid/ready handshake so the array can stall the stream.

## Interface
- dataSize, 8, element width in bits
- numRegister, 1024, register-file depth (elements); nAddress = $clog2(numRegister)
- maxKernelWidth, 3, largest supported kernel width
- nElementsOut, 9, output lanes (== nPEy); must be >= maxKernelWidth**2
---
- clk  in  1  clock, rising edge
- nrst  in  1  asynchronous, active-low reset
- wr_data  in  dataSize  register-file write data
- wr_addr  in  nAddress  register-file write address
- wr_en  in  1  write strobe
- cfg_ifmap_width  in  16  square ifmap side W
- cfg_kernel_width  in  4  kernel side K, 1..maxKernelWidth
- cfg_stride  in  4  stride S, >= 1
- cfg_pad  in  4  zero padding P on every border
- cfg_channels  in  16  channel count C, >= 1
- ctrl_start  in  1  start pulse, honoured only in S_IDLE
- ctrl_abort  in  1  abandon current run
- rd_data  out  dataSize x nElementsOut  window lanes
- out_valid  out  1  rd_data valid
- out_ready  in  1  consumer accepts rd_data
- flag_done  out  1  one-cycle pulse after last window accepted
- flag_error  out  1  one-cycle pulse on rejected config

## Operation
- Storage: channel-major; pixel (x,y,c) lives at addr c*W*W + y*W + x. Writes are accepted in every state. A read in the same cycle as a write to that address returns the old value.
- Config shadow: all cfg_* are sampled into shadow registers when ctrl_start is accepted. Later cfg changes do not affect the run.
- Wo = floor((W + 2P - K)/S) + 1. Compute in 18-bit signed arithmetic.
- Config check at start: reject if K==0, K>maxKernelWidth, S==0, C==0, or W+2P<K. On reject, pulse flag_error and remain in S_IDLE.
- Order: output y outer, output x middle, channel c inner. Total windows = Wo*Wo*C.
- Lane mapping: lane j*K+i = pixel (ox*S+i-P, oy*S+j-P, c), for i,j in 0..K-1.
- Zero fill, per lane:
  - coordinate <0 or >=W → 0
  - computed address >= numRegister → 0
  - lanes >= K*K → 0
- FSM:
  - S_IDLE: start with good config → S_RUN; bad config → flag_error pulse.
  - S_RUN: each cycle, if the output register is empty or (out_valid && out_ready), load the next window. After the last window's handshake → S_IDLE with flag_done=1 for one cycle.
  - ctrl_abort in S_RUN → S_IDLE next edge; out_valid drops; no flag_done.
- Backpressure: while out_valid && !out_ready, rd_data and counters hold. No window is skipped or duplicated.
- The register file is not cleared by done or abort, only by reset.

## Timing
- Reset values: rd_data all 0, out_valid 0, flag_done 0, flag_error 0, state S_IDLE, counters 0, register file all 0.
- Reset takes effect asynchronously at any time, including mid-run.
- ctrl_start sampled at edge E0 → state S_RUN after E0.
- First window registered at E1; out_valid=1 after E1.
- Throughput: 1 window/cycle with out_ready held high.
- Last handshake at edge En → after En: out_valid=0, flag_done=1 for one cycle, state S_IDLE.
- ctrl_start may be accepted on the cycle flag_done is high.
- flag_error is asserted for the cycle after the rejected start.
- Simultaneous ctrl_start and ctrl_abort in S_IDLE: start wins.
- ctrl_start is ignored in S_RUN.
- rd_data is registered; no combinational path from out_ready to rd_data.

## Test plan
- W=4, K=3, S=1, P=0, C=1, mem[a]=a, ready=1 → 4 windows on consecutive cycles. First {0,1,2,4,5,6,8,9,10}; last {5,6,7,9,10,11,13,14,15}; flag_done one cycle after the 4th handshake.
- W=3, K=3, S=1, P=1, mem[a]=a → 9 windows. Window (0,0) = {0,0,0,0,0,1,0,3,4}; window (2,2) = {4,5,0,7,8,0,0,0,0}.
- W=5, K=3, S=2, P=0 → Wo=2. Window (1,1) = {12,13,14,17,18,19,22,23,24}.
- W=3, K=2, C=2, mem[a]=a → order (0,0,c0), (0,0,c1). Windows {0,1,3,4,0,0,0,0,0} then {9,10,12,13,0,0,0,0,0}; 8 windows total; lanes 4..8 always 0.
- Backpressure: out_ready pattern 1,0,0,1,1,0,1 over the test-1 config → rd_data stable while stalled; the accepted sequence equals test 1 exactly.
- Control errors:
  - start with K=0 → flag_error one cycle, out_valid stays 0.
  - ctrl_abort after 2 handshakes → out_valid 0 next cycle, no flag_done; a new start replays from window (0,0).
  - nrst low mid-run → all outputs 0 immediately.
